// File: rtl/enigma_pkg.sv
// ---------------------------------------------------------------------------
// enigma_pkg
// Shared constants and types for the Enigma table-load path:
//   - table select encodings driven on table_idx
//   - default code width and table depths
//   - load-sequencer state encoding
// ---------------------------------------------------------------------------
package enigma_pkg;

  localparam int CODE_W     = 6;
  localparam int ROTA_DEPTH = 64;
  localparam int ROTB_DEPTH = 64;
  localparam int PLUG_DEPTH = 32;

  localparam logic [1:0] TBL_ROTA = 2'b00;
  localparam logic [1:0] TBL_ROTB = 2'b01;
  localparam logic [1:0] TBL_PLUG = 2'b10;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD_A = 3'd1,
    SEQ_LOAD_B = 3'd2,
    SEQ_LOAD_P = 3'd3,
    SEQ_DONE   = 3'd4
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/table_dup_check.sv
// ---------------------------------------------------------------------------
// table_dup_check
// Tracks which codes have been written into the table currently loading and
// flags a repeat. The seen-mask has one bit per possible code value.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   i_clr_mask   forget all seen codes (new table, start, abort)
//   i_clr_err    clear the sticky duplicate flag (start, abort)
//   i_chk        a code is being accepted this cycle
//   i_code       the accepted code
//   o_dup        sticky: some accepted code was already in the mask
// ---------------------------------------------------------------------------
module table_dup_check #(
  parameter int CODE_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_mask,
  input  logic              i_clr_err,
  input  logic              i_chk,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_dup
);
  import enigma_pkg::*;

  logic [2**CODE_W-1:0] r_mask;
  logic                 r_dup;

  // A code accepted on the same cycle as a mask clear belongs to the table
  // being closed, so it is checked against the old mask and not recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (i_clr_mask) begin
      r_mask <= '0;
    end else if (i_chk) begin
      r_mask[i_code] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dup <= 1'b0;
    end else if (i_clr_err) begin
      r_dup <= 1'b0;
    end else if (i_chk && r_mask[i_code]) begin
      r_dup <= 1'b1;
    end
  end

  assign o_dup = r_dup;

endmodule

// File: rtl/table_load_seq.sv
// ---------------------------------------------------------------------------
// table_load_seq
// Loads the Enigma lookup tables in order rotor A, rotor B, plugboard from a
// valid/ready stream of codes, issuing one registered shift strobe per
// accepted code to the selected table.
// Optional build macro: TABLE_LOAD_CHECK_EN adds duplicate-code detection
// per table (perm_err); without it perm_err is tied low.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        pulse, begins a load sequence from IDLE or DONE
//   abort        pulse, returns to IDLE (beats start)
//   cfg_valid    code present on cfg_data
//   cfg_data     code to load
//   cfg_ready    accepting codes (LOAD_A/B/P)
//   table_idx    target table of the current strobe
//   load         one-cycle shift strobe
//   code_out     code accompanying load
//   busy         sequence in progress
//   load_done    all tables loaded, held until start/abort
//   perm_err     sticky duplicate flag for the current table
// ---------------------------------------------------------------------------
module table_load_seq #(
  parameter int CODE_W     = enigma_pkg::CODE_W,
  parameter int ROTA_DEPTH = enigma_pkg::ROTA_DEPTH,
  parameter int ROTB_DEPTH = enigma_pkg::ROTB_DEPTH,
  parameter int PLUG_DEPTH = enigma_pkg::PLUG_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [CODE_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic [1:0]        table_idx,
  output logic              load,
  output logic [CODE_W-1:0] code_out,
  output logic              busy,
  output logic              load_done,
  output logic              perm_err
);
  import enigma_pkg::*;

  localparam int MAX_D = max3(ROTA_DEPTH, ROTB_DEPTH, PLUG_DEPTH);
  localparam int CNT_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ROTA_DEPTH - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(ROTB_DEPTH - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PLUG_DEPTH - 1);

  seq_state_e        r_state, w_nxt, w_adv;
  logic [CNT_W-1:0]  r_count, w_cnt_nxt, w_last_cnt;
  logic [1:0]        w_cur_idx;
  logic              w_ready, w_hs, w_last, w_start_ok;

  logic              r_load;
  logic [1:0]        r_idx;
  logic [CODE_W-1:0] r_code;

  assign w_ready    = (r_state == SEQ_LOAD_A) || (r_state == SEQ_LOAD_B) ||
                      (r_state == SEQ_LOAD_P);
  assign w_hs       = cfg_valid & w_ready;
  assign w_start_ok = start & ((r_state == SEQ_IDLE) || (r_state == SEQ_DONE));
  assign w_last     = w_hs && (r_count == w_last_cnt);

  // Per-state table selection, final count and successor state.
  always_comb begin
    w_cur_idx  = TBL_ROTA;
    w_last_cnt = '0;
    w_adv      = r_state;
    case (r_state)
      SEQ_LOAD_A: begin w_cur_idx = TBL_ROTA; w_last_cnt = A_LAST; w_adv = SEQ_LOAD_B; end
      SEQ_LOAD_B: begin w_cur_idx = TBL_ROTB; w_last_cnt = B_LAST; w_adv = SEQ_LOAD_P; end
      SEQ_LOAD_P: begin w_cur_idx = TBL_PLUG; w_last_cnt = P_LAST; w_adv = SEQ_DONE;   end
      default:    begin w_cur_idx = TBL_ROTA; w_last_cnt = '0;     w_adv = r_state;    end
    endcase
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_count;
    if (abort) begin
      w_nxt     = SEQ_IDLE;
      w_cnt_nxt = '0;
    end else if (w_start_ok) begin
      w_nxt     = SEQ_LOAD_A;
      w_cnt_nxt = '0;
    end else if (w_hs) begin
      if (w_last) begin
        w_nxt     = w_adv;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  // Strobe path: idx/code only move on an accepted code, so they hold the
  // last loaded value between strobes and across an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load <= 1'b0;
      r_idx  <= TBL_ROTA;
      r_code <= '0;
    end else if (abort) begin
      r_load <= 1'b0;
    end else begin
      r_load <= w_hs;
      if (w_hs) begin
        r_idx  <= w_cur_idx;
        r_code <= cfg_data;
      end
    end
  end

  assign cfg_ready = w_ready;
  assign busy      = w_ready;
  assign load      = r_load;
  assign table_idx = r_idx;
  assign code_out  = r_code;
  // DONE is entered on the same edge that issues the final strobe.
  assign load_done = (r_state == SEQ_DONE);

`ifdef TABLE_LOAD_CHECK_EN
  logic w_clr_mask, w_clr_err;
  assign w_clr_err  = abort | w_start_ok;
  assign w_clr_mask = w_clr_err | w_last;

  table_dup_check #(.CODE_W(CODE_W)) u_dup (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_mask (w_clr_mask),
    .i_clr_err  (w_clr_err),
    .i_chk      (w_hs & ~abort),
    .i_code     (cfg_data),
    .o_dup      (perm_err)
  );
`else
  assign perm_err = 1'b0;
`endif

endmodule

// File: tb/tb_table_load_seq.sv
module tb_table_load_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [5:0] cfg_data = '0;
  logic       cfg_ready, load, busy, load_done, perm_err;
  logic [1:0] table_idx;
  logic [5:0] code_out;

`ifdef TABLE_LOAD_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  table_load_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .table_idx(table_idx), .load(load), .code_out(code_out),
    .busy(busy), .load_done(load_done), .perm_err(perm_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_idx [4];

  typedef struct {
    logic       st, ab, v;
    logic [5:0] d;
    logic [12:0] exp;
  } vec_t;

  vec_t vt [10];

  function automatic logic [12:0] mk(input logic rdy, input logic ld, input logic [1:0] idx,
                                     input logic [5:0] code, input logic bsy, input logic dn);
    return {rdy, ld, idx, code, bsy, dn, 1'b0};
  endfunction

  function automatic logic [12:0] outs();
    return {cfg_ready, load, table_idx, code_out, busy, load_done, perm_err};
  endfunction

  function automatic logic [1:0] tbl_of(input int k);
    return (k < 64) ? 2'b00 : (k < 128) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams codes for handshakes from..to-1; reference: handshake k lands in
  // table tbl_of(k), appears on code_out one cycle later, done after k=159.
  task automatic run_stream(input int from, input int to, input bit gapped, input bit do_start);
    int m, cyc;
    logic v;
    logic [5:0] d;
    m = from;
    cyc = 0;
    if (do_start) begin
      cfg_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
    end
    while (m < to && cyc < 4000) begin
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      d = gapped ? 6'($urandom_range(0, 63)) : 6'(m % 64);
      cfg_valid = v;
      cfg_data  = d;
      chk("ready_in_load", {31'd0, cfg_ready}, 32'd1);
      step();
      if (v) begin
        m++;
        if (load) cnt_idx[table_idx]++;
        chk("load_strobe", {23'd0, load, table_idx, code_out}, {23'd0, 1'b1, tbl_of(m - 1), d});
        chk("load_done_timing", {31'd0, load_done}, {31'd0, (m == 160)});
      end else begin
        chk("no_load_on_gap", {31'd0, load}, 32'd0);
      end
      if (!gapped || !CHK_EN) chk("perm_clean", {31'd0, perm_err}, 32'd0);
      cyc++;
    end
    cfg_valid = 1'b0;
    if (m < to) chk("stream_timeout", m, to);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 6'd0,  mk(0, 0, 2'd0, 6'd0,  0, 0)};
    vt[1] = '{1'b1, 1'b1, 1'b0, 6'd0,  mk(0, 0, 2'd0, 6'd0,  0, 0)};
    vt[2] = '{1'b0, 1'b0, 1'b1, 6'd7,  mk(0, 0, 2'd0, 6'd0,  0, 0)};
    vt[3] = '{1'b1, 1'b0, 1'b0, 6'd0,  mk(1, 0, 2'd0, 6'd0,  1, 0)};
    vt[4] = '{1'b0, 1'b0, 1'b1, 6'd5,  mk(1, 1, 2'd0, 6'd5,  1, 0)};
    vt[5] = '{1'b0, 1'b0, 1'b0, 6'd0,  mk(1, 0, 2'd0, 6'd5,  1, 0)};
    vt[6] = '{1'b0, 1'b0, 1'b1, 6'd63, mk(1, 1, 2'd0, 6'd63, 1, 0)};
    vt[7] = '{1'b1, 1'b0, 1'b1, 6'd12, mk(1, 1, 2'd0, 6'd12, 1, 0)};
    vt[8] = '{1'b0, 1'b1, 1'b1, 6'd9,  mk(0, 0, 2'd0, 6'd12, 0, 0)};
    vt[9] = '{1'b0, 1'b0, 1'b1, 6'd3,  mk(0, 0, 2'd0, 6'd12, 0, 0)};

    // reset state
    #12;
    chk("reset_outputs", {19'd0, outs()}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single-cycle vectors: idle behaviour, start/abort priority, handshakes
    for (int i = 0; i < 10; i++) begin
      start = vt[i].st; abort = vt[i].ab; cfg_valid = vt[i].v; cfg_data = vt[i].d;
      step();
      chk($sformatf("vec%0d", i), {19'd0, outs()}, {19'd0, vt[i].exp});
    end
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;

    // full sequence, valid every cycle
    for (int i = 0; i < 4; i++) cnt_idx[i] = 0;
    run_stream(0, 160, 1'b0, 1'b1);
    chk("cnt_rota", cnt_idx[0], 64);
    chk("cnt_rotb", cnt_idx[1], 64);
    chk("cnt_plug", cnt_idx[2], 32);
    step();
    chk("done_hold", {19'd0, outs()}, {19'd0, mk(0, 0, 2'd2, 6'd31, 0, 1)});
    cfg_valid = 1'b1; cfg_data = 6'd7;
    step();
    chk("done_ignores_valid", {19'd0, outs()}, {19'd0, mk(0, 0, 2'd2, 6'd31, 0, 1)});
    cfg_valid = 1'b0;

    // randomly gapped stream, restarted from DONE
    for (int i = 0; i < 4; i++) cnt_idx[i] = 0;
    run_stream(0, 160, 1'b1, 1'b1);
    chk("gap_cnt_rota", cnt_idx[0], 64);
    chk("gap_cnt_rotb", cnt_idx[1], 64);
    chk("gap_cnt_plug", cnt_idx[2], 32);
    step();
    chk("gap_done", {29'd0, load, busy, load_done}, 32'b001);

    // abort after 70 handshakes, then restart
    run_stream(0, 70, 1'b0, 1'b1);
    abort = 1'b1; cfg_valid = 1'b1; cfg_data = 6'd44;
    step();
    abort = 1'b0;
    chk("abort_idle", {28'd0, cfg_ready, load, busy, load_done}, 32'd0);
    step();
    chk("abort_no_accept", {28'd0, cfg_ready, load, busy, load_done}, 32'd0);
    cfg_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0; cfg_valid = 1'b1; cfg_data = 6'd33;
    step();
    cfg_valid = 1'b0;
    chk("restart_first_load", {23'd0, load, table_idx, code_out}, {23'd0, 1'b1, 2'd0, 6'd33});
    abort = 1'b1; step(); abort = 1'b0;

    // start during LOAD_B is ignored and leaves the count alone
    run_stream(0, 70, 1'b0, 1'b1);
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 6'd6;
    step();
    start = 1'b0;
    chk("start_in_loadb", {22'd0, load, table_idx, code_out, busy}, {22'd0, 1'b1, 2'd1, 6'd6, 1'b1});
    run_stream(71, 160, 1'b0, 1'b0);
    step();
    chk("loadb_start_done", {31'd0, load_done}, 32'd1);

    // async reset mid plugboard load
    run_stream(0, 140, 1'b0, 1'b1);
    cfg_valid = 1'b1; cfg_data = 6'd12;
    #3 rst_n = 1'b0;
    #1 chk("async_reset", {19'd0, outs()}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_reset%0d", i), {19'd0, outs()}, 32'd0);
    end
    cfg_valid = 1'b0;

`ifdef TABLE_LOAD_CHECK_EN
    // duplicate detection in the plugboard
    run_stream(0, 128, 1'b0, 1'b1);
    cfg_valid = 1'b1; cfg_data = 6'd5; step();
    chk("perm_first5", {30'd0, load, perm_err}, 32'b10);
    cfg_data = 6'd9; step();
    chk("perm_9", {30'd0, load, perm_err}, 32'b10);
    cfg_data = 6'd5; step();
    chk("perm_dup5", {30'd0, load, perm_err}, 32'b11);
    cfg_valid = 1'b0; step();
    chk("perm_sticky", {31'd0, perm_err}, 32'd1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("perm_abort_clr", {31'd0, perm_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
